interrupt_coalescing_ctrl: RTL and testbench

INTERRUPT_COALESCING_CTRL -- requirements
Module: interrupt_coalescing_ctrl

---
 rtl/interrupt_coalescing_ctrl.sv | 168 ++++++++++++++++
 tb/tb_interrupt_coalescing_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_coalescing_ctrl.sv
// Interrupt coalescing controller.
// Counts RX completion events and raises a single interrupt once either the
// programmed event threshold is reached or a timeout has elapsed since the
// first event of a batch. The interrupt stays asserted until software acks it.
module interrupt_coalescing_ctrl #(
    parameter int cnt_width_p   = 8,
    parameter int timer_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     event_i,
    input  logic                     ack_i,
    input  logic [cnt_width_p-1:0]   thresh_i,
    input  logic                     thresh_v_i,
    input  logic [timer_width_p-1:0] timeout_i,
    input  logic                     timeout_v_i,
    input  logic                     enable_i,
    input  logic                     enable_v_i,
    output logic                     irq_o,
    output logic [cnt_width_p-1:0]   count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_FIRE  = 2'b10
    } state_e;

    localparam logic [cnt_width_p-1:0]   cnt_zero_lp = {cnt_width_p{1'b0}};
    localparam logic [cnt_width_p-1:0]   cnt_one_lp  = {{(cnt_width_p-1){1'b0}}, 1'b1};
    localparam logic [cnt_width_p-1:0]   cnt_max_lp  = {cnt_width_p{1'b1}};
    localparam logic [timer_width_p-1:0] tmr_zero_lp = {timer_width_p{1'b0}};
    localparam logic [timer_width_p-1:0] tmr_one_lp  = {{(timer_width_p-1){1'b0}}, 1'b1};

    // Saturating increment: the event count parks at all-ones instead of wrapping.
    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] val,
                                                       input logic                   inc);
        logic [cnt_width_p-1:0] res;
        if (inc && (val != cnt_max_lp)) begin
            res = val + cnt_one_lp;
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_e                   state_q,   state_d;
    logic [cnt_width_p-1:0]   count_q,   count_d;
    logic [timer_width_p-1:0] timer_q,   timer_d;
    logic [cnt_width_p-1:0]   thresh_q,  thresh_d;
    logic [timer_width_p-1:0] timeout_q, timeout_d;
    logic                     enable_q,  enable_d;
    logic                     irq_q,     irq_d;

    logic [cnt_width_p-1:0]   thresh_eff_s;
    logic                     thresh_is_one_s;
    logic                     timer_hit_s;
    logic [cnt_width_p-1:0]   count_inc_s;

    // Derived compare terms; a zero threshold behaves as "fire on every event",
    // and ">=" on the timer makes a lowered timeout fire on the next COUNT cycle.
    always_comb begin
        if (thresh_q == cnt_zero_lp) begin
            thresh_eff_s = cnt_one_lp;
        end else begin
            thresh_eff_s = thresh_q;
        end
        thresh_is_one_s = (thresh_eff_s == cnt_one_lp);
        if (timeout_q != tmr_zero_lp) begin
            timer_hit_s = (timer_q >= (timeout_q - tmr_one_lp));
        end else begin
            timer_hit_s = 1'b0;
        end
        count_inc_s = sat_inc(count_q, event_i);
    end

    // Configuration registers: a strobe loads new data, otherwise hold.
    always_comb begin
        if (thresh_v_i) begin
            thresh_d = thresh_i;
        end else begin
            thresh_d = thresh_q;
        end
        if (timeout_v_i) begin
            timeout_d = timeout_i;
        end else begin
            timeout_d = timeout_q;
        end
        if (enable_v_i) begin
            enable_d = enable_i;
        end else begin
            enable_d = enable_q;
        end
    end

    // Coalescing FSM next-state, count and timer; the FSM keeps running while
    // masked so a pending FIRE shows up as soon as the enable is set.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (event_i) begin
                    count_d = cnt_one_lp;
                    timer_d = tmr_zero_lp;
                    state_d = thresh_is_one_s ? ST_FIRE : ST_COUNT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COUNT: begin
                count_d = count_inc_s;
                if ((count_inc_s >= thresh_eff_s) || timer_hit_s) begin
                    state_d = ST_FIRE;
                end else if (timeout_q != tmr_zero_lp) begin
                    timer_d = timer_q + tmr_one_lp;
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_FIRE: begin
                if (ack_i && event_i) begin
                    count_d = cnt_one_lp;
                    timer_d = tmr_zero_lp;
                    state_d = thresh_is_one_s ? ST_FIRE : ST_COUNT;
                end else if (ack_i) begin
                    count_d = cnt_zero_lp;
                    timer_d = tmr_zero_lp;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = cnt_zero_lp;
                timer_d = tmr_zero_lp;
            end
        endcase
        irq_d = (state_d == ST_FIRE) && enable_d;
    end

    // State and configuration flops with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            count_q   <= cnt_zero_lp;
            timer_q   <= tmr_zero_lp;
            thresh_q  <= cnt_one_lp;
            timeout_q <= tmr_zero_lp;
            enable_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            thresh_q  <= thresh_d;
            timeout_q <= timeout_d;
            enable_q  <= enable_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_o   = irq_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_interrupt_coalescing_ctrl.sv
// Testbench for interrupt_coalescing_ctrl: directed scenarios plus random
// traffic, every cycle compared against a behavioural coalescing model.
module tb_interrupt_coalescing_ctrl;

    localparam int CW = 4;
    localparam int TW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          event_i = 1'b0;
    logic          ack_i = 1'b0;
    logic [CW-1:0] thresh_i = '0;
    logic          thresh_v_i = 1'b0;
    logic [TW-1:0] timeout_i = '0;
    logic          timeout_v_i = 1'b0;
    logic          enable_i = 1'b0;
    logic          enable_v_i = 1'b0;
    logic          irq_o;
    logic [CW-1:0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: a batch is "open" after its first event, "fired" once
    // the threshold or the timeout condition is met, until software acks it
    bit m_open, m_fired, m_enable, m_irq;
    int m_count, m_elapsed, m_thresh, m_timeout;

    interrupt_coalescing_ctrl #(.cnt_width_p(CW), .timer_width_p(TW)) dut (
        .clk_i(clk), .reset_i(reset_i), .event_i(event_i), .ack_i(ack_i),
        .thresh_i(thresh_i), .thresh_v_i(thresh_v_i),
        .timeout_i(timeout_i), .timeout_v_i(timeout_v_i),
        .enable_i(enable_i), .enable_v_i(enable_v_i),
        .irq_o(irq_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_start(input int thr_eff);
        m_count   = 1;
        m_elapsed = 0;
        if (thr_eff == 1) begin
            m_fired = 1'b1;
            m_open  = 1'b0;
        end else begin
            m_fired = 1'b0;
            m_open  = 1'b1;
        end
    endtask

    task automatic model_clock();
        int thr_eff;
        if (reset_i) begin
            m_open = 0; m_fired = 0; m_count = 0; m_elapsed = 0;
            m_thresh = 1; m_timeout = 0; m_enable = 0; m_irq = 0;
            return;
        end
        thr_eff = (m_thresh == 0) ? 1 : m_thresh;
        if (m_fired) begin
            if (ack_i && event_i) begin
                model_start(thr_eff);
            end else if (ack_i) begin
                m_fired = 0; m_open = 0; m_count = 0; m_elapsed = 0;
            end else begin
                m_count = (m_count + int'(event_i) > CMAX) ? CMAX : m_count + int'(event_i);
            end
        end else if (m_open) begin
            m_count = (m_count + int'(event_i) > CMAX) ? CMAX : m_count + int'(event_i);
            if (m_count >= thr_eff || (m_timeout != 0 && m_elapsed + 1 >= m_timeout)) begin
                m_fired = 1; m_open = 0;
            end else if (m_timeout != 0) begin
                m_elapsed++;
            end
        end else if (event_i) begin
            model_start(thr_eff);
        end
        if (thresh_v_i)  m_thresh  = int'(thresh_i);
        if (timeout_v_i) m_timeout = int'(timeout_i);
        if (enable_v_i)  m_enable  = enable_i;
        m_irq = m_fired && m_enable;
    endtask

    // one clock: inputs already driven; update model at the edge, check after it
    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check_val("irq_model", int'(irq_o), int'(m_irq));
        check_val("count_model", int'(count_o), m_count);
        reset_i = 0; event_i = 0; ack_i = 0;
        thresh_v_i = 0; timeout_v_i = 0; enable_v_i = 0;
    endtask

    task automatic cfg(input int en, input int thr, input int tmo);
        enable_i = en[0]; enable_v_i = 1;
        thresh_i = thr[CW-1:0]; thresh_v_i = 1;
        timeout_i = tmo[TW-1:0]; timeout_v_i = 1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        @(negedge clk);
        reset_i = 1; tick();
        reset_i = 1; tick();
        check_val("reset_irq", int'(irq_o), 0);
        check_val("reset_count", int'(count_o), 0);

        // threshold firing
        cfg(1, 4, 0);
        for (int k = 0; k < 3; k++) begin
            event_i = 1; tick(); idle(1);
        end
        check_val("thr_before_irq", int'(irq_o), 0);
        check_val("thr_before_cnt", int'(count_o), 3);
        event_i = 1; tick();
        check_val("thr_irq", int'(irq_o), 1);
        check_val("thr_cnt", int'(count_o), 4);
        ack_i = 1; tick();
        check_val("ack_irq", int'(irq_o), 0);
        check_val("ack_cnt", int'(count_o), 0);

        // timeout firing
        cfg(1, 4, 10);
        event_i = 1; tick();
        idle(9);
        check_val("tmo_before_irq", int'(irq_o), 0);
        idle(1);
        check_val("tmo_irq", int'(irq_o), 1);
        check_val("tmo_cnt", int'(count_o), 1);
        ack_i = 1; tick();

        // ack with simultaneous event
        cfg(1, 2, 0);
        event_i = 1; tick();
        event_i = 1; tick();
        check_val("ackev_fire_irq", int'(irq_o), 1);
        ack_i = 1; event_i = 1; tick();
        check_val("ackev_irq", int'(irq_o), 0);
        check_val("ackev_cnt", int'(count_o), 1);
        event_i = 1; tick();
        check_val("ackev_refire_irq", int'(irq_o), 1);
        ack_i = 1; tick();

        // lowering the timeout below the running timer
        cfg(1, 15, 20);
        event_i = 1; tick();
        idle(8);
        timeout_i = 16'd3; timeout_v_i = 1; tick();
        check_val("lower_tmo_hold", int'(irq_o), 0);
        idle(1);
        check_val("lower_tmo_irq", int'(irq_o), 1);
        ack_i = 1; tick();

        // masking
        cfg(0, 1, 0);
        event_i = 1; tick();
        check_val("mask_irq", int'(irq_o), 0);
        check_val("mask_cnt", int'(count_o), 1);
        enable_i = 1; enable_v_i = 1; tick();
        check_val("unmask_irq", int'(irq_o), 1);
        ack_i = 1; tick();

        // saturation with a zero threshold
        cfg(1, 0, 0);
        for (int k = 0; k < 20; k++) begin
            event_i = 1; tick();
        end
        check_val("sat_cnt", int'(count_o), 15);
        check_val("sat_irq", int'(irq_o), 1);

        // reset during FIRE
        reset_i = 1; tick();
        check_val("rst_fire_irq", int'(irq_o), 0);
        check_val("rst_fire_cnt", int'(count_o), 0);
        enable_i = 1; enable_v_i = 1; tick();
        event_i = 1; tick();
        check_val("rst_thr1_irq", int'(irq_o), 1);
        check_val("rst_thr1_cnt", int'(count_o), 1);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            event_i     = ($urandom_range(0, 99) < 35);
            ack_i       = ($urandom_range(0, 99) < 12);
            thresh_v_i  = ($urandom_range(0, 99) < 3);
            thresh_i    = CW'($urandom_range(0, CMAX));
            timeout_v_i = ($urandom_range(0, 99) < 3);
            timeout_i   = TW'($urandom_range(0, 25));
            enable_v_i  = ($urandom_range(0, 99) < 3);
            enable_i    = ($urandom_range(0, 99) < 75);
            reset_i     = ($urandom_range(0, 999) < 5);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
